// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg: shared types and constants for the program-load sequencer.
//   state_t          - sequencer FSM encoding
//   LINE_BYTES       - bytes per cache line / DMA request
//   LINE_OFFSET_BITS - log2(LINE_BYTES), shift from line index to byte address
package proc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_UNHALT,
        S_RUN,
        S_DONE,
        S_DRAIN
    } state_t;

    localparam int LINE_BYTES       = 64;
    localparam int LINE_OFFSET_BITS = 6;

endpackage

// File: rtl/rd_req_tracker.sv
// rd_req_tracker: counts DMA read requests accepted and responses received.
// Shared by the load phase (bounds requests, detects the last response) and
// the drain phase (detects when every in-flight read has returned).
//   clk, rst_n    - clock, async active-low reset
//   clr           - zero both counters (new program load)
//   acc           - a request was accepted this cycle
//   rsp           - a response arrived this cycle
//   size          - lines in the current program
//   issued_nxt    - request count after this cycle's update
//   received      - response count before this cycle's update (imem index)
//   all_issued    - issued_nxt == size
//   all_received  - received count after this cycle == size
//   outstanding   - reads still in flight after this cycle
module rd_req_tracker #(
    parameter int SIZE_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  acc,
    input  logic                  rsp,
    input  logic [SIZE_WIDTH-1:0] size,
    output logic [SIZE_WIDTH-1:0] issued_nxt,
    output logic [SIZE_WIDTH-1:0] received,
    output logic                  all_issued,
    output logic                  all_received,
    output logic                  outstanding
);

    logic [SIZE_WIDTH-1:0] issued;
    logic [SIZE_WIDTH-1:0] received_nxt;

    // Flags look at post-update counts so the FSM can act on the cycle in
    // which the last accept/response happens rather than one cycle later.
    always_comb begin
        issued_nxt   = clr ? '0 : issued + SIZE_WIDTH'(acc);
        received_nxt = clr ? '0 : received + SIZE_WIDTH'(rsp);
        all_issued   = (issued_nxt == size);
        all_received = (received_nxt == size);
        outstanding  = (issued_nxt != received_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued   <= '0;
            received <= '0;
        end else begin
            issued   <= issued_nxt;
            received <= received_nxt;
        end
    end

endmodule

// File: rtl/proc_ctrl.sv
// proc_ctrl: program-load and run sequencer.
// On go, DMA-reads `size` lines from start_addr into instruction memory,
// holds the core halted until unhalt, runs it until it reports halted, then
// raises done. Software reset aborts any phase and drains in-flight reads.
//   clk, rst_n                          - clock, async active-low reset
//   go, reset, unhalt                   - software controls
//   start_addr, size                    - program base (64B aligned), line count
//   done                                - high in DONE only
//   dma_rd_en/addr/ready                - read request channel
//   dma_rd_valid/data                   - in-order read response channel
//   imem_wr_en/addr/data                - instruction-memory write port
//   core_halt, core_rst, core_halted    - core control / status
module proc_ctrl
    import proc_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int SIZE_WIDTH = 16,
    parameter int LINE_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic                  reset,
    input  logic                  unhalt,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [SIZE_WIDTH-1:0] size,
    output logic                  done,
    output logic                  dma_rd_en,
    output logic [ADDR_WIDTH-1:0] dma_rd_addr,
    input  logic                  dma_rd_ready,
    input  logic                  dma_rd_valid,
    input  logic [LINE_WIDTH-1:0] dma_rd_data,
    output logic                  imem_wr_en,
    output logic [SIZE_WIDTH-1:0] imem_wr_addr,
    output logic [LINE_WIDTH-1:0] imem_wr_data,
    output logic                  core_halt,
    output logic                  core_rst,
    input  logic                  core_halted
);

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] base_q, base_eff, line_off;
    logic [SIZE_WIDTH-1:0] size_q, size_eff;
    logic                  rd_en_q;
    logic                  go_take, rd_acc, rd_rsp;
    logic [SIZE_WIDTH-1:0] issued_nxt, received;
    logic                  all_issued, all_received, outstanding;

    // go only starts a load from IDLE/DONE and never while soft reset is held.
    assign go_take  = go && !reset && (state == S_IDLE || state == S_DONE);
    assign base_eff = go_take ? start_addr : base_q;
    assign size_eff = go_take ? size : size_q;

    // The request is registered, but soft reset must kill it in the same
    // cycle so no new read is accepted once an abort is requested.
    assign dma_rd_en = rd_en_q && !reset;
    assign rd_acc    = dma_rd_en && dma_rd_ready;
    assign rd_rsp    = dma_rd_valid && (state == S_LOAD || state == S_DRAIN);

    // Byte offset of the next line; wraps silently at ADDR_WIDTH.
    assign line_off = ADDR_WIDTH'({issued_nxt, {LINE_OFFSET_BITS{1'b0}}});

    rd_req_tracker #(
        .SIZE_WIDTH(SIZE_WIDTH)
    ) u_trk (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (go_take),
        .acc         (rd_acc),
        .rsp         (rd_rsp),
        .size        (size_eff),
        .issued_nxt  (issued_nxt),
        .received    (received),
        .all_issued  (all_issued),
        .all_received(all_received),
        .outstanding (outstanding)
    );

    always_comb begin
        state_nxt = state;
        if (reset) begin
            state_nxt = outstanding ? S_DRAIN : S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (go_take) state_nxt = (size == '0) ? S_WAIT_UNHALT : S_LOAD;
                S_LOAD:         if (all_received) state_nxt = S_WAIT_UNHALT;
                S_WAIT_UNHALT:  if (unhalt) state_nxt = S_RUN;
                S_RUN:          if (core_halted) state_nxt = S_DONE;
                S_DRAIN:        if (!outstanding) state_nxt = S_IDLE;
                default:        state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            base_q       <= '0;
            size_q       <= '0;
            rd_en_q      <= 1'b0;
            dma_rd_addr  <= '0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
            done         <= 1'b0;
            core_halt    <= 1'b1;
            core_rst     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (go_take) begin
                base_q <= start_addr;
                size_q <= size;
            end
            rd_en_q     <= (state_nxt == S_LOAD) && !all_issued;
            dma_rd_addr <= base_eff + line_off;
            // Responses during an abort are counted by the tracker but
            // never written into imem.
            imem_wr_en  <= (state == S_LOAD) && dma_rd_valid && !reset;
            if ((state == S_LOAD) && dma_rd_valid && !reset) begin
                imem_wr_addr <= received;
                imem_wr_data <= dma_rd_data;
            end
            done      <= (state_nxt == S_DONE);
            core_halt <= (state_nxt != S_RUN);
            core_rst  <= reset;
        end
    end

endmodule
